// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared definitions for the pushbutton conditioner:
//   - per-key debounce FSM state encoding
//   - field layout of the 32-bit button register image
//   - default debounce length and the derived debounce counter width
// No ports; imported by key_conditioner_if, key_debounce and key_conditioner.
// -----------------------------------------------------------------------------
package key_cond_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_WAIT_DOWN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_WAIT_UP   = 2'd3
    } key_state_e;

    localparam int KEY_COUNT = 4;

    // 5 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEBOUNCE_CYCLES);

    // button_word layout
    localparam int WORD_W    = 32;
    localparam int LEVEL_LSB = 0;   // debounced levels, 1 = pressed
    localparam int LEVEL_W   = KEY_COUNT;
    localparam int FLAG_LSB  = 4;   // sticky press flags
    localparam int FLAG_W    = KEY_COUNT;
    localparam int RSVD_LSB  = 8;   // reads as zero
    localparam int RSVD_W    = 8;
    localparam int PCNT_LSB  = 16;  // key k counter at PCNT_LSB + PCNT_W*k
    localparam int PCNT_W    = 4;

endpackage

// File: rtl/key_conditioner_if.sv
// -----------------------------------------------------------------------------
// key_conditioner_if
// Host-facing bundle of the conditioner.
//   clr_valid   host -> dut  request to clear flags/counters selected by clr_mask
//   clr_mask    host -> dut  per-key clear select
//   clr_ready   dut  -> host clear acknowledge (1 whenever out of reset)
//   press_pulse dut  -> host one-cycle strobe per accepted press
//   button_word dut  -> host register image for the PCIe button PIO
// master = host side, slave = key_conditioner side.
// -----------------------------------------------------------------------------
interface key_conditioner_if;
    import key_cond_pkg::*;

    logic                 clr_valid;
    logic [KEY_COUNT-1:0] clr_mask;
    logic                 clr_ready;
    logic [KEY_COUNT-1:0] press_pulse;
    logic [WORD_W-1:0]    button_word;

    modport master (
        output clr_valid,
        output clr_mask,
        input  clr_ready,
        input  press_pulse,
        input  button_word
    );

    modport slave (
        input  clr_valid,
        input  clr_mask,
        output clr_ready,
        output press_pulse,
        output button_word
    );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One pushbutton: two-flop synchronizer, four-state debounce FSM and press
// strobe. A level change is accepted once the synchronized key has held the
// new value for DEBOUNCE_CYCLES+1 consecutive samples; any bounce back to the
// old value abandons the attempt.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high
//   key_raw  asynchronous raw key, active-low
//   level    registered debounced level, 1 = pressed (DOWN / WAIT_UP)
//   press    registered one-cycle strobe on entry into DOWN
// -----------------------------------------------------------------------------
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic             pressed;
    key_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to "released" so a key held through reset is seen
    // as a fresh press once reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= key_raw;
            sync_q    <= sync_meta;
        end
    end

    assign pressed = ~sync_q;

    // level and press are updated on the same edge as the state so they carry
    // no extra register delay relative to the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_UP;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the default below is
            // overridden by a later assignment in the same cycle, not raced.
            press <= 1'b0;
            case (state)
                ST_UP: begin
                    if (pressed) begin
                        state <= ST_WAIT_DOWN;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_DOWN: begin
                    if (!pressed) begin
                        state <= ST_UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_DOWN;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (!pressed) begin
                        state <= ST_WAIT_UP;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_UP: begin
                    // A bounce back to pressed returns to DOWN silently: the
                    // key never left, so it is not a new press.
                    if (pressed) begin
                        state <= ST_DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_UP;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Debounces N_KEYS active-low pushbuttons, keeps a sticky press flag and a
// wrapping 4-bit press counter per key, and packs everything into the 32-bit
// button_word image. The host clears flags/counters per key via clr_valid /
// clr_mask; a clear coinciding with a press of the same key is applied first.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high
//   key_raw  asynchronous raw keys, active-low
//   bus      key_conditioner_if.slave (clear handshake, press_pulse,
//            button_word)
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int N_KEYS          = KEY_COUNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    key_conditioner_if.slave  bus
);

    logic [N_KEYS-1:0]             level;
    logic [N_KEYS-1:0]             pulse;
    logic [N_KEYS-1:0]             flag;
    logic [N_KEYS-1:0][PCNT_W-1:0] press_cnt;
    logic                          clr_ready_q;
    logic                          clr_fire;
    logic [WORD_W-1:0]             word;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk    (clk),
            .reset  (reset),
            .key_raw(key_raw[k]),
            .level  (level[k]),
            .press  (pulse[k])
        );
    end

    assign clr_fire = bus.clr_valid & clr_ready_q;

    // Flags and counters follow the registered press strobe, so a clear issued
    // during the strobe cycle lands on the same edge as the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ready_q <= 1'b0;
            flag        <= '0;
            // NOTE: the counter bank is host-visible state, so every entry is
            // reset explicitly rather than left to power-up values.
            press_cnt   <= '0;
        end else begin
            clr_ready_q <= 1'b1;
            for (int k = 0; k < N_KEYS; k++) begin
                if (pulse[k]) begin
                    flag[k]      <= 1'b1;
                    press_cnt[k] <= (clr_fire && bus.clr_mask[k]) ? PCNT_W'(1)
                                                                  : press_cnt[k] + PCNT_W'(1);
                end else if (clr_fire && bus.clr_mask[k]) begin
                    flag[k]      <= 1'b0;
                    press_cnt[k] <= '0;
                end
            end
        end
    end

    // Pure wiring of registered fields; no logic sits between flops and pins.
    always_comb begin
        // NOTE: full default first so no bit of the word can infer a latch.
        word                              = '0;
        word[LEVEL_LSB +: LEVEL_W]        = level;
        word[FLAG_LSB  +: FLAG_W]         = flag;
        word[RSVD_LSB  +: RSVD_W]         = '0;
        word[PCNT_LSB  +: PCNT_W*N_KEYS]  = press_cnt;
    end

    assign bus.button_word = word;
    assign bus.press_pulse = pulse;
    assign bus.clr_ready   = clr_ready_q;

endmodule
